demux14_sched: RTL and testbench

Round-robin dispatcher that sequences the 1:4 demultiplexer. It accepts a stream of beats on a single valid/ready input and registers each accepted beat. It then presents that beat to exactly one of four consumers, choosing them in rotating order and skipping channels masked off by software. It sits between a single producer and four identical downstream consumers, and replaces direct `{s0,s1}` driving of the demux with a handshaked, fair schedule.

---
 rtl/demux14_sched_if.sv | 25 ++
 rtl/demux14_sched.sv | 83 ++++++++
 tb/tb_demux14_sched.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux14_sched_if.sv
// Handshake bundle between one producer, the dispatcher and four consumers.
`timescale 1ns/1ps
interface demux14_sched_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [3:0]       en_mask;
    logic [3:0]       out_valid;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_ready;
    logic [1:0]       sel;
    logic [15:0]      count;

    modport slave (
        input  in_valid, in_data, en_mask, out_ready,
        output in_ready, out_valid, out_data, sel, count
    );

    modport master (
        output in_valid, in_data, en_mask, out_ready,
        input  in_ready, out_valid, out_data, sel, count
    );
endinterface

// File: rtl/demux14_sched.sv
// Round-robin dispatcher: one registered beat offered to exactly one of
// four consumers, chosen in rotating order over the enabled channels.
`timescale 1ns/1ps
module demux14_sched #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    demux14_sched_if.slave        bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [15:0]      count_q, count_d;

    logic       deliver;
    logic       in_ready;
    logic       accept;
    logic [1:0] pick;
    logic [1:0] idx;

    assign deliver  = (state_q == FULL) && bus.out_ready[sel_q];
    assign in_ready = !rst && (bus.en_mask != 4'b0000)
                      && ((state_q == EMPTY) || bus.out_ready[sel_q]);
    assign accept   = bus.in_valid && in_ready;

    // Descending scan so the enabled channel nearest to ptr wins.
    always_comb begin
        pick = ptr_q;
        idx  = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (bus.en_mask[idx]) pick = idx;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (deliver) count_d = count_q + 16'd1;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (deliver && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            data_d = bus.in_data;
            sel_d  = pick;
            ptr_d  = pick + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == FULL) ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.out_data  = data_q;
    assign bus.sel       = sel_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_demux14_sched.sv
// Randomized and directed bench for demux14_sched against a spec-level model.
`timescale 1ns/1ps
module tb_demux14_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux14_sched_if #(.WIDTH(8)) bus ();

    demux14_sched #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Spec-level model state
    bit       armed = 1'b0;
    bit       m_valid;
    bit [7:0] m_data;
    int       m_sel;
    int       m_ptr;
    int       m_count;

    // Deliveries seen on the DUT outputs
    int       log_ch[$];
    bit [7:0] log_d[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_enabled(bit [3:0] en, int ptr);
        for (int k = 0; k < 4; k++)
            if (en[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    always @(posedge clk) begin
        bit dlv;
        bit rdy;
        int c;
        if (rst) begin
            armed   = 1'b1;
            m_valid = 1'b0;
            m_data  = 8'h00;
            m_sel   = 0;
            m_ptr   = 0;
            m_count = 0;
        end else if (armed) begin
            dlv = m_valid && bus.out_ready[m_sel];
            rdy = (bus.en_mask != 0) && (!m_valid || dlv);
            if (dlv) begin
                m_count = (m_count + 1) % 65536;
                m_valid = 1'b0;
            end
            if (bus.in_valid && rdy) begin
                c       = first_enabled(bus.en_mask, m_ptr);
                m_data  = bus.in_data;
                m_sel   = c;
                m_ptr   = (c + 1) % 4;
                m_valid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        bit exp_rdy;
        if (armed) begin
            exp_rdy = !rst && (bus.en_mask != 0)
                      && (!m_valid || bus.out_ready[m_sel]);
            chk("m_out_valid", bus.out_valid, m_valid ? (32'd1 << m_sel) : 0);
            chk("m_out_data", bus.out_data, m_data);
            chk("m_sel", bus.sel, m_sel);
            chk("m_count", bus.count, m_count);
            chk("m_in_ready", bus.in_ready, exp_rdy);
            if (!rst) begin
                for (int k = 0; k < 4; k++)
                    if (bus.out_valid[k] && bus.out_ready[k]) begin
                        log_ch.push_back(k);
                        log_d.push_back(bus.out_data);
                    end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_log(string name, int chs[], bit [7:0] ds[]);
        chk({name, "_n"}, log_ch.size(), chs.size());
        for (int i = 0; i < chs.size() && i < log_ch.size(); i++) begin
            chk({name, "_ch"}, log_ch[i], chs[i]);
            chk({name, "_d"}, log_d[i], ds[i]);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.en_mask   = 4'b1111;
        bus.out_ready = 4'b1111;
        rst = 1'b1;
        step();
        step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Back-to-back rotation over all four channels
        log_ch.delete();
        log_d.delete();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 8'h10 + 8'(i);
            #1;
            chk("t1_in_ready", bus.in_ready, 1);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        check_log("t1", '{0, 1, 2, 3, 0}, '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14});
        chk("t1_count", bus.count, 5);

        // Masked rotation over channels 1 and 3
        log_ch.delete();
        log_d.delete();
        bus.en_mask  = 4'b1010;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 8'hA0 + 8'(i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        check_log("t2", '{1, 3, 1, 3}, '{8'hA0, 8'hA1, 8'hA2, 8'hA3});
        bus.en_mask  = 4'b0001;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB0;
        step();
        bus.in_valid = 1'b0;
        chk("t2_sel0", bus.sel, 0);
        chk("t2_ov0", bus.out_valid, 4'b0001);
        step();

        // Stalled consumer on channel 2
        log_ch.delete();
        log_d.delete();
        bus.en_mask   = 4'b0100;
        bus.out_ready = 4'b1011;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h55;
        step();
        bus.in_data = 8'h56;
        #1;
        chk("t3_ov", bus.out_valid, 4'b0100);
        chk("t3_data", bus.out_data, 8'h55);
        chk("t3_in_ready", bus.in_ready, 0);
        step();
        chk("t3_hold", bus.out_data, 8'h55);
        bus.out_ready = 4'b1111;
        #1;
        chk("t3_in_ready_up", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("t3_next_data", bus.out_data, 8'h56);
        chk("t3_next_ov", bus.out_valid, 4'b0100);
        step();
        check_log("t3", '{2, 2}, '{8'h55, 8'h56});

        // Empty mask: nothing accepted, held beat still drains
        log_ch.delete();
        log_d.delete();
        bus.en_mask   = 4'b0010;
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h66;
        step();
        bus.en_mask = 4'b0000;
        bus.in_data = 8'h67;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t4_in_ready", bus.in_ready, 0);
            step();
        end
        chk("t4_held", bus.out_valid, 4'b0010);
        bus.out_ready = 4'b1111;
        step();
        chk("t4_drained", bus.out_valid, 4'b0000);
        bus.in_valid = 1'b0;
        check_log("t4", '{1}, '{8'h66});

        // Reset while a beat is held
        bus.en_mask   = 4'b0010;
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h77;
        step();
        bus.in_valid = 1'b0;
        chk("t5_held", bus.sel, 1);
        rst = 1'b1;
        #1;
        chk("t5_in_ready", bus.in_ready, 0);
        step();
        chk("t5_ov", bus.out_valid, 0);
        chk("t5_count", bus.count, 0);
        chk("t5_sel", bus.sel, 0);
        rst = 1'b0;
        bus.en_mask   = 4'b1111;
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h78;
        step();
        bus.in_valid = 1'b0;
        chk("t5_first_ch", bus.out_valid, 4'b0001);
        step();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_data   = 8'($urandom);
            bus.out_ready = 4'($urandom);
            if ($urandom_range(7) == 0) bus.en_mask = 4'($urandom);
            rst = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0;

        // Counter wrap
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.en_mask   = 4'b0001;
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            bus.in_data = 8'(i);
            step();
        end
        bus.in_valid = 1'b0;
        chk("t6_pre_wrap", bus.count, 16'hFFFF);
        step();
        chk("t6_wrap", bus.count, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
